// File: rtl/tsc_rx.sv
// Host-side receiver for the trigger/serial-capture link: requests the
// captured buffer with SBF, deframes SD bytes into a local RAM until CD.
module tsc_rx #(
    parameter int AW      = 5,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arm,
    input  logic          TRD,
    input  logic          CD,
    input  logic          SD,
    output logic          SBF,
    output logic [7:0]    rx_byte,
    output logic          rx_valid,
    output logic [AW:0]   rx_count,
    output logic          done,
    output logic          frame_err,
    output logic          overflow,
    output logic          timeout,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] HUNT = 3'd2;
    localparam logic [2:0] DATA = 3'd3;
    localparam logic [2:0] STOP = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]    state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] timer;
    logic [7:0]    shreg;
    logic [7:0]    mem [2**AW];
    logic          wr_en;

    // rx_count[AW] is set only at the full count, so it doubles as "full"
    assign wr_en = (state == STOP) && SD && !rx_count[AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            timer     <= '0;
            shreg     <= '0;
            SBF       <= 1'b0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            rx_count  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            SBF      <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm && TRD) begin
                        state     <= REQ;
                        SBF       <= 1'b1;
                        rx_count  <= '0;
                        done      <= 1'b0;
                        frame_err <= 1'b0;
                        overflow  <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                REQ: begin
                    state <= HUNT;
                    timer <= '0;
                end
                HUNT: begin
                    timer <= timer + TW'(1);
                    if (!SD) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end else if (CD) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (timer == TLAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                DATA: begin
                    shreg   <= {shreg[6:0], SD};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        state <= STOP;
                end
                STOP: begin
                    state <= HUNT;
                    timer <= '0;
                    if (!SD) begin
                        frame_err <= 1'b1;
                    end else if (rx_count[AW]) begin
                        overflow <= 1'b1;
                    end else begin
                        rx_count <= rx_count + (AW+1)'(1);
                        rx_byte  <= shreg;
                        rx_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!arm) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Buffer RAM keeps its contents across reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[rx_count[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_tsc_rx.sv
// Directed bench for tsc_rx: frame table plus hand sequences for
// overflow, timeout, CD mid-byte and asynchronous reset.
module tb_tsc_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm, TRD, CD, SD;
    logic       SBF;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [5:0] rx_count;
    logic       done, frame_err, overflow, timeout;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;

    int checks   = 0;
    int failures = 0;
    int vcnt     = 0;
    int sbf_cnt  = 0;

    typedef struct {
        logic       new_cap;
        logic [7:0] data;
        logic       stop;
        logic [5:0] cnt;
        logic       ferr;
        logic [7:0] byt;
    } vec_t;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] exp;
    } rd_t;

    vec_t vec [5];
    rd_t  rdv [3];

    tsc_rx #(.AW(5), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .arm(arm), .TRD(TRD), .CD(CD), .SD(SD),
        .SBF(SBF), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_count(rx_count), .done(done), .frame_err(frame_err),
        .overflow(overflow), .timeout(timeout),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) vcnt++;
        if (SBF) sbf_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_capture();
        arm = 1'b1;
        TRD = 1'b1;
        @(negedge clk);
        check("sbf_hi", 32'(SBF), 32'd1);
        check("req_clr", 32'({rx_count, done, frame_err, overflow, timeout}), 32'd0);
        TRD = 1'b0;
        @(negedge clk);
        check("sbf_lo", 32'(SBF), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {1'b0, b, stop};
        for (int i = 9; i >= 0; i--) begin
            SD = f[i];
            @(negedge clk);
        end
        SD = 1'b1;
    endtask

    task automatic end_capture();
        CD = 1'b1;
        @(negedge clk);
        check("done_hi", 32'(done), 32'd1);
        CD  = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        check("done_lo", 32'(done), 32'd0);
    endtask

    task automatic rd_check(input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(negedge clk);
        check($sformatf("rd[%0d]", a), 32'(rd_data), 32'(exp));
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vec[i].new_cap) start_capture();
            send_frame(vec[i].data, vec[i].stop);
            check($sformatf("row%0d_cnt", i), 32'(rx_count), 32'(vec[i].cnt));
            check($sformatf("row%0d_ferr", i), 32'(frame_err), 32'(vec[i].ferr));
            check($sformatf("row%0d_byte", i), 32'(rx_byte), 32'(vec[i].byt));
        end
    endtask

    initial begin
        int v0;
        int s0;
        int cnt;
        logic [9:0] f;

        vec[0] = '{1'b1, 8'hD5, 1'b1, 6'd1, 1'b0, 8'hD5};
        vec[1] = '{1'b0, 8'h12, 1'b1, 6'd2, 1'b0, 8'h12};
        vec[2] = '{1'b0, 8'hFF, 1'b1, 6'd3, 1'b0, 8'hFF};
        vec[3] = '{1'b1, 8'hA5, 1'b0, 6'd0, 1'b1, 8'hFF};
        vec[4] = '{1'b0, 8'h3C, 1'b1, 6'd1, 1'b1, 8'h3C};
        rdv[0] = '{5'd0, 8'hD5};
        rdv[1] = '{5'd1, 8'h12};
        rdv[2] = '{5'd2, 8'hFF};

        reset = 1'b1; arm = 1'b0; TRD = 1'b0; CD = 1'b0; SD = 1'b1;
        rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", 32'({SBF, rx_byte, rx_valid, rx_count, done,
              frame_err, overflow, timeout, rd_data}), 32'd0);
        reset = 1'b0;
        TRD = 1'b1;
        repeat (3) @(negedge clk);
        check("no_arm_sbf", 32'(sbf_cnt), 32'd0);
        TRD = 1'b0;

        // Basic capture: three back-to-back bytes then CD
        v0 = vcnt;
        run_rows(0, 2);
        end_capture();
        check("basic_valid", 32'(vcnt - v0), 32'd3);
        check("basic_cnt", 32'(rx_count), 32'd3);
        check("basic_sbf", 32'(sbf_cnt), 32'd1);
        for (int i = 0; i < 3; i++) rd_check(rdv[i].addr, rdv[i].exp);

        // Framing error followed by a good byte
        run_rows(3, 4);
        end_capture();
        rd_check(5'd0, 8'h3C);

        // Read-during-write returns old data, then async reset mid-byte
        rd_addr = 5'd0;
        start_capture();
        send_frame(8'h5A, 1'b1);
        check("rdw_old", 32'(rd_data), 32'h3C);
        @(negedge clk);
        check("rdw_new", 32'(rd_data), 32'h5A);
        send_frame(8'hA5, 1'b0);
        check("pre_rst", 32'({rx_count, frame_err, rx_byte}), 32'({6'd1, 1'b1, 8'h5A}));
        SD = 1'b0; @(negedge clk);
        SD = 1'b1; @(negedge clk);
        SD = 1'b0; @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst", 32'({SBF, rx_byte, rx_valid, rx_count, done,
              frame_err, overflow, timeout, rd_data}), 32'd0);
        @(negedge clk);
        reset = 1'b0; arm = 1'b0; TRD = 1'b0; SD = 1'b1;
        s0 = sbf_cnt;
        repeat (2) @(negedge clk);
        check("rst_no_sbf", 32'(sbf_cnt - s0), 32'd0);
        start_capture();
        end_capture();
        check("rst_sbf_once", 32'(sbf_cnt - s0), 32'd1);

        // CD raised during a data bit is deferred until the byte completes
        start_capture();
        f = {1'b0, 8'h77, 1'b1};
        for (int i = 9; i >= 0; i--) begin
            SD = f[i];
            if (i == 5) CD = 1'b1;
            @(negedge clk);
        end
        SD = 1'b1;
        check("cdmid_nodone", 32'(done), 32'd0);
        check("cdmid_cnt", 32'(rx_count), 32'd1);
        check("cdmid_byte", 32'(rx_byte), 32'h77);
        @(negedge clk);
        check("cdmid_done", 32'(done), 32'd1);
        CD = 1'b0; arm = 1'b0;
        @(negedge clk);

        // Timeout: idle line, no CD
        start_capture();
        cnt = 0;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("to_cycles", 32'(cnt), 32'd64);
        check("to_flag", 32'(timeout), 32'd1);
        check("to_cnt", 32'(rx_count), 32'd0);
        arm = 1'b0;
        @(negedge clk);
        check("to_idle", 32'({done, timeout}), 32'b01);

        // Overflow: 33 good bytes into a 32-entry buffer
        v0 = vcnt;
        start_capture();
        for (int i = 0; i < 33; i++) send_frame(8'(i), 1'b1);
        check("ovf_cnt", 32'(rx_count), 32'd32);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_ferr", 32'(frame_err), 32'd0);
        check("ovf_byte", 32'(rx_byte), 32'h1F);
        end_capture();
        check("ovf_valid", 32'(vcnt - v0), 32'd32);
        rd_check(5'd31, 8'h1F);
        rd_check(5'd0, 8'h00);
        rd_check(5'd16, 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
